// File: rtl/sincos_poly_mc.sv
// sincos_poly_mc: tagged sin/cos requests time-multiplexed over one
// polynomial sine pipeline, reassembled into a credit-protected FIFO.

module sin_poly_q22 (
    input  logic signed [23:0] theta,
    output logic signed [23:0] sin_out
);
    // Odd Taylor coefficients of sin(x) in Q34, Horner form in x^2
    localparam logic signed [47:0] C1  =  48'sd17179869184;
    localparam logic signed [47:0] C3  = -48'sd2863311531;
    localparam logic signed [47:0] C5  =  48'sd143165577;
    localparam logic signed [47:0] C7  = -48'sd3408704;
    localparam logic signed [47:0] C9  =  48'sd47343;
    localparam logic signed [47:0] C11 = -48'sd430;
    localparam logic signed [47:0] C13 =  48'sd3;

    function automatic logic signed [47:0] mulq(
        input logic signed [47:0] a,
        input logic signed [47:0] b
    );
        logic signed [95:0] aw;
        logic signed [95:0] bw;
        aw = {{48{a[47]}}, a};
        bw = {{48{b[47]}}, b};
        return 48'((aw * bw) >>> 34);
    endfunction

    logic signed [47:0] x;
    logic signed [47:0] x2;
    logic signed [47:0] p;
    logic signed [47:0] s;
    logic signed [47:0] r;

    // Polynomial evaluation, rounding to Q1.23 and saturation at +/-1
    always_comb begin
        x  = {{12{theta[23]}}, theta, 12'b0};
        x2 = mulq(x, x);
        p  = C13;
        p  = C11 + mulq(x2, p);
        p  = C9 + mulq(x2, p);
        p  = C7 + mulq(x2, p);
        p  = C5 + mulq(x2, p);
        p  = C3 + mulq(x2, p);
        p  = C1 + mulq(x2, p);
        s  = mulq(x, p);
        r  = (s + 48'sd1024) >>> 11;
        if (r > 48'sd8388607) begin
            sin_out = 24'sh7FFFFF;
        end else if (r < -48'sd8388608) begin
            sin_out = 24'sh800000;
        end else begin
            sin_out = r[23:0];
        end
    end
endmodule

module sincos_poly_mc #(
    parameter int N_CH       = 8,
    parameter int LAT        = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH_W-1:0]        in_ch,
    input  logic [1:0]             in_mode,
    input  logic signed [23:0]     in_theta,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [1:0]             out_mode,
    output logic signed [23:0]     out_sin,
    output logic signed [23:0]     out_cos,
    output logic                   out_clip,
    output logic                   busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [23:0] HALF_PI = 24'sh6487ED;

    typedef struct packed {
        logic            v;
        logic [CH_W-1:0] ch;
        logic [1:0]      mode;
        logic            clip;
        logic            is_cos;
        logic            last;
        logic [23:0]     data;
    } slot_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [1:0]      mode;
        logic            clip;
        logic [23:0]     sin_v;
        logic [23:0]     cos_v;
    } beat_t;

    typedef enum logic {S_IDLE, S_COS} state_t;

    state_t state_q, state_d;
    slot_t  iss_q, iss_d;
    slot_t  pipe_q [LAT];
    slot_t  pipe_d [LAT];
    slot_t  tail;
    beat_t  mem_q [FIFO_DEPTH];
    beat_t  mem_d [FIFO_DEPTH];
    beat_t  wr_beat;
    beat_t  head;

    logic [23:0]     hold_arg_q, hold_arg_d;
    logic [CH_W-1:0] hold_ch_q, hold_ch_d;
    logic            hold_clip_q, hold_clip_d;
    logic [23:0]     sin_hold_q, sin_hold_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   credits_q, credits_d;

    logic signed [23:0] th_c;
    logic signed [23:0] th_abs;
    logic signed [23:0] cos_arg;
    logic signed [23:0] core_out;
    logic               clip;
    logic [1:0]         mode_n;
    logic               accept;
    logic               wr_en;
    logic               pop;

    // Clamp the angle, derive the cos argument and normalise the mode
    always_comb begin
        clip = 1'b0;
        th_c = in_theta;
        if (in_theta > HALF_PI) begin
            th_c = HALF_PI;
            clip = 1'b1;
        end else if (in_theta < -HALF_PI) begin
            th_c = -HALF_PI;
            clip = 1'b1;
        end
        th_abs  = th_c[23] ? -th_c : th_c;
        cos_arg = HALF_PI - th_abs;
        mode_n  = (in_mode == 2'b11) ? 2'b00 : in_mode;
    end

    assign accept = in_valid && in_ready;

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Issue FSM next state: sin+cos requests need a second issue cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && mode_n == 2'b00) state_d = S_COS;
            S_COS:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Issue FSM outputs: handshake and the slot entering the pipeline
    always_comb begin
        in_ready    = 1'b0;
        iss_d       = '0;
        hold_arg_d  = hold_arg_q;
        hold_ch_d   = hold_ch_q;
        hold_clip_d = hold_clip_q;
        unique case (state_q)
            S_IDLE: begin
                in_ready = rst_n && (credits_q != '0);
                if (in_valid && in_ready) begin
                    iss_d.v      = 1'b1;
                    iss_d.ch     = in_ch;
                    iss_d.mode   = mode_n;
                    iss_d.clip   = clip;
                    iss_d.is_cos = (mode_n == 2'b10);
                    iss_d.last   = (mode_n != 2'b00);
                    iss_d.data   = (mode_n == 2'b10) ? cos_arg : th_c;
                    hold_arg_d   = cos_arg;
                    hold_ch_d    = in_ch;
                    hold_clip_d  = clip;
                end
            end
            S_COS: begin
                iss_d.v      = 1'b1;
                iss_d.ch     = hold_ch_q;
                iss_d.mode   = 2'b00;
                iss_d.clip   = hold_clip_q;
                iss_d.is_cos = 1'b1;
                iss_d.last   = 1'b1;
                iss_d.data   = hold_arg_q;
            end
            default: in_ready = 1'b0;
        endcase
    end

    sin_poly_q22 u_core (
        .theta   (iss_q.data),
        .sin_out (core_out)
    );

    // Result pipeline: tags travel with the polynomial output
    always_comb begin
        pipe_d[0]      = iss_q;
        pipe_d[0].data = core_out;
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    assign tail = pipe_q[LAT-1];

    // Reassembly: park a leading sin, emit a beat on the last slot
    always_comb begin
        sin_hold_d = sin_hold_q;
        wr_en      = tail.v && tail.last;
        wr_beat    = '0;
        if (tail.v && !tail.last) sin_hold_d = tail.data;
        wr_beat.ch   = tail.ch;
        wr_beat.mode = tail.mode;
        wr_beat.clip = tail.clip;
        if (tail.is_cos) begin
            wr_beat.cos_v = tail.data;
            if (tail.mode == 2'b00) wr_beat.sin_v = sin_hold_q;
        end else begin
            wr_beat.sin_v = tail.data;
        end
    end

    assign pop = (cnt_q != '0) && out_ready;

    // Result FIFO and credit bookkeeping
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = wr_beat;
        wr_ptr_d  = wr_ptr_q + PW'(wr_en);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        cnt_d     = cnt_q + CW'(wr_en) - CW'(pop);
        credits_d = credits_q - CW'(accept) + CW'(pop);
    end

    // Datapath registers; reset discards all in-flight work
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_q       <= '0;
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            hold_arg_q  <= '0;
            hold_ch_q   <= '0;
            hold_clip_q <= 1'b0;
            sin_hold_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            credits_q   <= CW'(FIFO_DEPTH);
        end else begin
            iss_q       <= iss_d;
            pipe_q      <= pipe_d;
            mem_q       <= mem_d;
            hold_arg_q  <= hold_arg_d;
            hold_ch_q   <= hold_ch_d;
            hold_clip_q <= hold_clip_d;
            sin_hold_q  <= sin_hold_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            credits_q   <= credits_d;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Present the FIFO head, forced to zero while empty
    always_comb begin
        out_valid = (cnt_q != '0);
        out_ch    = '0;
        out_mode  = '0;
        out_clip  = 1'b0;
        out_sin   = '0;
        out_cos   = '0;
        if (out_valid) begin
            out_ch   = head.ch;
            out_mode = head.mode;
            out_clip = head.clip;
            out_sin  = head.sin_v;
            out_cos  = head.cos_v;
        end
    end

    // Busy while anything is issuing, in flight or queued
    always_comb begin
        busy = (state_q != S_IDLE) || iss_q.v || (cnt_q != '0);
        for (int i = 0; i < LAT; i++) busy = busy || pipe_q[i].v;
    end
endmodule

// File: doc/sincos_poly_mc.md
# sincos_poly_mc

Multi-channel, handshaked successor to the dual-phase sin/cos generator. It runs on one clock and time-multiplexes a single `sin_poly_q22` evaluation pipeline across up to `N_CH` tagged angle requests. Each request selects sin, cos or both, and the block returns one reassembled output beat per request through a credit-protected result FIFO. It sits between the oscillator/phase-accumulator bank and the modulation/mixing stages of the audio signal chain.

## Interface
- `N_CH`, 8, number of logical channels; `CH_W = max(1, $clog2(N_CH))`
- `LAT`, 8, register stages after the combinational `sin_poly_q22` core; minimum 1
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, minimum 2
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at the rising edge
- `in_ch`  in  CH_W  channel tag, passed through unchanged
- `in_mode`  in  2  00 = sin+cos, 01 = sin only, 10 = cos only, 11 = treated as 00
- `in_theta`  in  24  signed Q2.22 radians; legal range [-HALF_PI, +HALF_PI], HALF_PI = 0x6487ED
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out_ch`  out  CH_W  tag of the request
- `out_mode`  out  2  mode as issued; 11 is reported as 00
- `out_sin`  out  24  signed Q1.23; 0 when the mode excludes sin
- `out_cos`  out  24  signed Q1.23; 0 when the mode excludes cos
- `out_clip`  out  1  `in_theta` was outside the legal range and was clamped
- `busy`  out  1  request in the issue FSM, slots in flight, or FIFO non-empty

## Operation
- **Clamp:** `in_theta` above HALF_PI is clamped to HALF_PI. `in_theta` below -HALF_PI is clamped to -HALF_PI. `out_clip` is set for that beat.
- **Cos argument:** `HALF_PI - |theta_clamped|`, always in [0, HALF_PI]. No wrap logic is required. |0x800000| is unreachable because the clamp is applied first.
- **Issue FSM, S_IDLE:**
  - `in_ready = (credits != 0)`.
  - On accept, issue the first slot in the same cycle: sin for modes 00/01, cos for 10.
  - Mode 00 moves to S_COS and latches the cos argument, tag and clip flag.
  - Modes 01/10 stay in S_IDLE.
- **Issue FSM, S_COS:** `in_ready = 0`. Issue the cos slot, then return to S_IDLE.
- **Slot pipeline:** each slot carries {valid, ch, mode, clip, is_cos, last} through `LAT` registers alongside the data.
  - A slot is issued on every cycle it is requested; there is no stall.
  - `last` is set on the cos slot in mode 00, and on the only slot in modes 01/10.
- **Reassembly:**
  - A non-last sin slot is held in a sin register.
  - A last slot writes one FIFO entry. The held sin value is used for mode 00; the unused field is 0.
- **Credits:**
  - Counter resets to `FIFO_DEPTH`.
  - Decrement on accept; increment on FIFO pop; unchanged when both happen in the same cycle.
  - This guarantees the FIFO never overflows. Writes into a full FIFO cannot occur; the bench asserts this.
- **Output:** `out_*` are the registered FIFO head. `out_valid = !empty`. Ordering is strictly FIFO per acceptance order, across all channels.
- **Reset (`rst_n` = 0 at an edge):**
  - Pipeline valid bits cleared, FIFO emptied, credits = `FIFO_DEPTH`, FSM = S_IDLE.
  - All `out_*` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst_n` = 0.
  - Any in-flight work is discarded, with no partial beat emitted afterwards.

## Timing
- Define the accepting edge as E0.
- **Mode 01/10:** result reaches the pipeline tail at E_LAT and is written to the FIFO at E_{LAT+1}. `out_valid` is high after E_{LAT+1} when the FIFO was empty.
- **Mode 00:** cos is issued at E1 and reaches the tail at E_{LAT+1}. The FIFO write is at E_{LAT+2}.
- **Throughput:** 1 request/cycle for single modes; 1 request per 2 cycles for mode 00.
- **Pop:** pop and write in the same cycle are both honoured. A full FIFO with a pop still accepts a write because of the credit invariant.
- **`busy`:** falls the cycle after the final pop.

## Test plan
- **Zero angle:** `in_theta`=0x000000, mode 00, `out_ready`=1 → one beat after E_{LAT+2}; `out_sin` = 0 ±2 LSB, `out_cos` = 0x7FFFFF ±2 LSB, `out_clip`=0.
- **Range limits and clamp:**
  - `in_theta`=0x6487ED → `out_sin` ≈ 0x7FFFFF, `out_cos` ≈ 0.
  - 0x9B7813 → `out_sin` ≈ 0x800001, `out_cos` ≈ 0.
  - 0x7FFFFF → same result as 0x6487ED, with `out_clip`=1.
- **Mixed traffic:** channels 0..7 back-to-back, modes cycling 00/01/10, `out_ready`=1.
  - Outputs arrive in order with matching `out_ch`/`out_mode`.
  - The excluded field is 0.
  - `in_ready` pattern is 1,0 after each mode-00 accept.
- **Backpressure:** `out_ready`=0, `FIFO_DEPTH`=4, continuous `in_valid`.
  - Exactly 4 accepts, then `in_ready`=0 indefinitely.
  - Raising `out_ready` gives 4 in-order pops; `in_ready` returns the cycle after the first pop.
- **Reset mid-operation:** `rst_n` low for 1 cycle at E3 after 3 accepts → `out_valid` never rises for those requests, credits = 4, `busy`=0 on the next cycle.
- **Reference model:** random `in_theta` in range against an IEEE sin/cos model → every result within ±2 LSB.
